db_initiator: RTL and testbench
===============================

// Module: db_initiator
// PURPOSE
//  Bus-master end of the DataBus.vh memory interface: takes one load/store/fetch request from the
//  CPU core, drives db_* to the memory/IO responder, waits for db_ready, returns read data
//  (big-endian, byte-at-lowest-address = MSB) with optional sign extension. Sits between
//  the core's memory stage and the MMU/bus. Flags misaligned and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYCLES  255  bus cycles waiting for db_ready before fault; 0 disables timeout
//  CNT_W           8    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1    clock, all state on rising edge
//  res            in   1    reset, asynchronous, active-low
//  req_valid      in   1    core presents a request
//  req_ready      out  1    initiator can accept a request (high only in IDLE)
//  req_type       in   `MEM_ACCESS  R, W or X
//  req_len        in   `MEM_LEN     B, H or W
//  req_signed     in   1    sign-extend B/H reads
//  req_io         in   1    IO-space access
//  req_addr       in   32   byte address
//  req_wdata      in   32   write data, right-justified
//  resp_valid     out  1    one-cycle pulse: request finished
//  resp_data      out  32   read data (0 for writes/faults)
//  resp_fault     out  2    00 ok, 01 misaligned, 10 timeout
//  db_accessType  out  `MEM_ACCESS  `MEM_ACCESS_NONE when idle
//  db_memLen      out  `MEM_LEN
//  db_io          out  1
//  db_addr        out  32
//  db_dataOut     out  32   write data, right-justified
//  db_dataIn      in   32   read data from responder, right-justified
//  db_ready       in   1    responder accepts the current access
// BEHAVIOUR
//  Reset (res=0, async): state IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_fault=00;
//   db_accessType=`MEM_ACCESS_NONE; db_memLen=`MEM_LEN_W; db_io=0; db_addr=0; db_dataOut=0;
//   timeout counter=0. Reset mid-access abandons it; no resp_valid is produced.
//  FSM: IDLE -> BUS -> RDATA -> DONE -> IDLE (writes skip RDATA; misaligned goes IDLE -> DONE).
//  IDLE: on req_valid&req_ready latch all req_* fields. Misaligned (H with addr[0]=1; W with
//   addr[1:0]!=0; X must be W with addr[1:0]==0) -> DONE, fault 01, no bus cycle issued.
//   Otherwise -> BUS with db_* driven from registers the next cycle.
//  BUS: db_* held stable every cycle. Edge with db_ready=1 completes handshake: W -> DONE,
//   R/X -> RDATA; db_accessType returns to NONE the cycle after. Counter +1 per cycle with
//   db_ready=0; when it reaches TIMEOUT_CYCLES -> DONE, fault 10, bus set to NONE.
//  RDATA: responder registers data at the handshake edge; sample db_dataIn at this cycle's
//   edge. B: [7:0], H: [15:0], zero- or sign-extended per req_signed; W/X: as-is.
//  DONE: resp_valid=1 for exactly one cycle with resp_data/resp_fault; -> IDLE, counter cleared.
//  Latency (db_ready=1): write 2 cycles accept->resp_valid, read 3; misaligned 1.
//  req_ready=0 outside IDLE; req_* changes then are ignored. Back-to-back: new request may be
//   accepted the cycle after resp_valid. db_dataOut low bits = req_wdata for B/H, upper masked 0.
//  req_type=`MEM_ACCESS_NONE with req_valid: ignored, stays IDLE.
// STRUCTURE
//  `MEM_ACCESS/`MEM_LEN widths and codes (incl. `MEM_ACCESS_NONE) live in DataBus.vh; FSM state
//   localparams and fault codes go in DataBus.vh as `DB_FAULT_*. One sub-module natural:
//   db_load_extend (combinational len/signed extension of read data), reused by the MMU.
// TESTING
//  Bench pairs db_initiator with the team's dummy memory responder (db_ready tie-able low/random).
//  1 W write 0xDEADBEEF @0x100, then R W @0x100 -> mem[0x100..3]=DE AD BE EF, resp_data=0xDEADBEEF.
//  2 R B @0x101 signed, mem=0xAD -> 0xFFFFFFAD; unsigned -> 0x000000AD; R H @0x102 signed -> 0xFFFFBEEF.
//  3 R H @0x103 -> resp_fault=01 one cycle after accept, db_accessType never leaves NONE.
//  4 db_ready held 0, TIMEOUT_CYCLES=4 -> resp_fault=10 after 4 BUS cycles, bus returns NONE.
//  5 W B io=1 addr=1 data=0x41 -> responder sees db_io=1, prints 'A'; random db_ready stalls
//   -> db_* stable every stalled cycle; exactly one resp_valid per request.
//  6 res low while in BUS -> all outputs at reset values asynchronously, no resp_valid.

Source files
------------

// File: rtl/db_initiator_pkg.sv
// Shared DataBus types: access/length codes, fault codes, initiator FSM states
// and small helpers used by the initiator and by the load-extension block.
package db_initiator_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_NONE = 2'd0,
        MEM_ACCESS_R    = 2'd1,
        MEM_ACCESS_W    = 2'd2,
        MEM_ACCESS_X    = 2'd3
    } mem_access_e;

    typedef enum logic [1:0] {
        MEM_LEN_B = 2'd0,
        MEM_LEN_H = 2'd1,
        MEM_LEN_W = 2'd2
    } mem_len_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } db_state_e;

    localparam logic [1:0] DB_FAULT_OK       = 2'b00;
    localparam logic [1:0] DB_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] DB_FAULT_TIMEOUT  = 2'b10;

    // Instruction fetches are always full aligned words.
    function automatic logic is_misaligned(input mem_access_e t, input mem_len_e l,
                                           input logic [1:0] a);
        logic m;
        case (l)
            MEM_LEN_B: m = 1'b0;
            MEM_LEN_H: m = a[0];
            default:   m = |a;
        endcase
        if (t == MEM_ACCESS_X && l != MEM_LEN_W) m = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] wdata_mask(input mem_len_e l, input logic [31:0] w);
        logic [31:0] r;
        case (l)
            MEM_LEN_B: r = {24'h0, w[7:0]};
            MEM_LEN_H: r = {16'h0, w[15:0]};
            default:   r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/db_load_extend.sv
// Combinational read-data extraction: picks the right-justified byte/half/word
// from the responder and zero- or sign-extends it to 32 bits.
module db_load_extend
    import db_initiator_pkg::*;
(
    input  mem_len_e    len,
    input  logic        is_signed,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (len)
            MEM_LEN_B: data = {{24{is_signed & raw[7]}}, raw[7:0]};
            MEM_LEN_H: data = {{16{is_signed & raw[15]}}, raw[15:0]};
            default:   data = raw;
        endcase
    end

endmodule

// File: rtl/db_initiator.sv
// DataBus master: accepts one core request at a time, runs a single bus access
// with optional timeout, and returns a one-cycle response with data and fault code.
module db_initiator
    import db_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_access_e req_type,
    input  mem_len_e    req_len,
    input  logic        req_signed,
    input  logic        req_io,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_fault,
    output mem_access_e db_accessType,
    output mem_len_e    db_memLen,
    output logic        db_io,
    output logic [31:0] db_addr,
    output logic [31:0] db_dataOut,
    input  logic [31:0] db_dataIn,
    input  logic        db_ready,
    output db_state_e   dbg_state
);

    // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
    // a bus access completes on a rising edge where db_accessType != NONE and db_ready.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    db_state_e        state_q, state_d;
    mem_access_e      acc_q, acc_d;
    mem_len_e         len_q, len_d;
    logic             io_q, io_d;
    logic             signed_q, signed_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ext_data;

    db_load_extend u_load_extend (
        .len       (len_q),
        .is_signed (signed_q),
        .raw       (db_dataIn),
        .data      (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        len_d    = len_q;
        io_d     = io_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_type != MEM_ACCESS_NONE) begin
                    len_d    = req_len;
                    io_d     = req_io;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = wdata_mask(req_len, req_wdata);
                    data_d   = '0;
                    cnt_d    = '0;
                    if (is_misaligned(req_type, req_len, req_addr[1:0])) begin
                        fault_d = DB_FAULT_MISALIGN;
                        state_d = ST_DONE;
                    end else begin
                        fault_d = DB_FAULT_OK;
                        acc_d   = req_type;
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (db_ready) begin
                    acc_d   = MEM_ACCESS_NONE;
                    state_d = (acc_q == MEM_ACCESS_W) ? ST_DONE : ST_RDATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (TO_EN && cnt_q == TO_LAST) begin
                        acc_d   = MEM_ACCESS_NONE;
                        fault_d = DB_FAULT_TIMEOUT;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RDATA: begin
                data_d  = ext_data;
                state_d = ST_DONE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= ST_IDLE;
            acc_q    <= MEM_ACCESS_NONE;
            len_q    <= MEM_LEN_W;
            io_q     <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            fault_q  <= DB_FAULT_OK;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            len_q    <= len_d;
            io_q     <= io_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_DONE);
    assign resp_data     = resp_valid ? data_q : '0;
    assign resp_fault    = resp_valid ? fault_q : DB_FAULT_OK;
    assign db_accessType = acc_q;
    assign db_memLen     = len_q;
    assign db_io         = io_q;
    assign db_addr       = addr_q;
    assign db_dataOut    = wdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_db_initiator.sv
// Bench for db_initiator: dummy byte memory responder, byte-array reference
// model, expected-response queue popped by a monitor on resp_valid.
module tb_db_initiator;
  import db_initiator_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  mem_access_e req_type = MEM_ACCESS_NONE;
  mem_len_e    req_len = MEM_LEN_W;
  logic        req_signed = 1'b0;
  logic        req_io = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;
  mem_access_e db_access_type;
  mem_len_e    db_mem_len;
  logic        db_io;
  logic [31:0] db_addr;
  logic [31:0] db_data_out;
  logic [31:0] db_data_in;
  logic        db_ready = 1'b1;
  db_state_e   dbg_state;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  logic [7:0]  ref_mem[0:1023];
  logic [7:0]  bus_mem[0:1023];
  logic [31:0] rd_reg = '0;
  logic [7:0]  io_char = '0;
  int          io_writes = 0;
  int          ready_mode = 0;
  int          stall_run = 0;

  db_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_len(req_len),
    .req_signed(req_signed), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .db_accessType(db_access_type), .db_memLen(db_mem_len), .db_io(db_io),
    .db_addr(db_addr), .db_dataOut(db_data_out), .db_dataIn(db_data_in),
    .db_ready(db_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nbytes_of(input mem_len_e l);
    return (l == MEM_LEN_B) ? 1 : (l == MEM_LEN_H) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // reference model: big-endian byte array, plain arithmetic
  function automatic logic [31:0] ref_read(input int a, input int n, input bit sg);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[(a + i) % 1024]);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_write(input int a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 1024] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  // dummy memory responder
  assign db_data_in = rd_reg;

  always @(posedge clk) begin
    if (res && db_access_type != MEM_ACCESS_NONE && db_ready) begin
      int n;
      logic [31:0] v;
      n = nbytes_of(db_mem_len);
      if (db_access_type == MEM_ACCESS_W) begin
        for (int i = 0; i < n; i++)
          bus_mem[(int'(db_addr[9:0]) + i) % 1024] = 8'(db_data_out >> (8 * (n - 1 - i)));
        if (db_io) begin
          io_char = db_data_out[7:0];
          io_writes++;
          $display("io write: %c", db_data_out[7:0]);
        end
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(bus_mem[(int'(db_addr[9:0]) + i) % 1024]);
        rd_reg <= v;
      end
    end
  end

  // db_ready driver: 0 = always ready, 1 = random with at most 2 stalls in a row, 2 = held low
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: db_ready = 1'b1;
        1: begin
          if (stall_run >= 2) db_ready = 1'b1;
          else db_ready = 1'($urandom_range(0, 1));
          stall_run = db_ready ? 0 : stall_run + 1;
        end
        default: db_ready = 1'b0;
      endcase
    end
  end

  // monitor: scoreboard pop on resp_valid, bus stability while stalled
  mem_access_e prev_acc = MEM_ACCESS_NONE;
  logic        prev_rdy = 1'b1;
  logic [36:0] prev_ctl = '0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    logic [33:0] e;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_fault", 64'(resp_fault), 64'(e[33:32]));
        check("resp_data", 64'(resp_data), 64'(e[31:0]));
      end
    end
    if (prev_acc != MEM_ACCESS_NONE && !prev_rdy && db_access_type != MEM_ACCESS_NONE) begin
      check("bus_stable_ctl", 64'({db_access_type, db_mem_len, db_io, db_data_out}), 64'(prev_ctl));
      check("bus_stable_addr", 64'(db_addr), 64'(prev_addr));
    end
    prev_acc  = db_access_type;
    prev_rdy  = db_ready;
    prev_ctl  = {db_access_type, db_mem_len, db_io, db_data_out};
    prev_addr = db_addr;
  end

  // driver: issue one request, push expected response, wait for it
  task automatic send(input mem_access_e t, input mem_len_e l, input bit sg, input bit io,
                      input logic [31:0] a, input logic [31:0] wd);
    int n, mode, exp_lat, lat;
    bit mis, got;
    logic [33:0] e;
    n = nbytes_of(l);
    mode = ready_mode;
    mis = (int'(a % 32'(n)) != 0) || (t == MEM_ACCESS_X && l != MEM_LEN_W);
    if (mis) begin
      e = {DB_FAULT_MISALIGN, 32'h0};
      exp_lat = 1;
    end else if (mode == 2) begin
      e = {DB_FAULT_TIMEOUT, 32'h0};
      exp_lat = TO + 1;
    end else if (t == MEM_ACCESS_W) begin
      ref_write(int'(a[9:0]), n, wd);
      e = {DB_FAULT_OK, 32'h0};
      exp_lat = 2;
    end else begin
      e = {DB_FAULT_OK, ref_read(int'(a[9:0]), n, sg)};
      exp_lat = 3;
    end
    @(negedge clk);
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_type = t; req_len = l; req_signed = sg; req_io = io;
    req_addr = a; req_wdata = wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    req_signed = 1'($urandom_range(0, 1));
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (mis) check("misalign_no_bus", 64'(db_access_type), 64'(MEM_ACCESS_NONE));
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
    check("resp_seen", 64'(got), 64'd1);
    if (got && mode != 1) check("latency", 64'(lat), 64'(exp_lat));
    if (got && mode == 2 && !mis) check("timeout_bus_none", 64'(db_access_type), 64'(MEM_ACCESS_NONE));
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_fault", 64'(resp_fault), 64'd0);
    check("rst_acc", 64'(db_access_type), 64'(MEM_ACCESS_NONE));
    check("rst_len", 64'(db_mem_len), 64'(MEM_LEN_W));
    check("rst_io", 64'(db_io), 64'd0);
    check("rst_addr", 64'(db_addr), 64'd0);
    check("rst_dout", 64'(db_data_out), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    mem_access_e t;
    mem_len_e    l;
    logic [31:0] a;
    int          n;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom_range(0, 255));
      bus_mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    check_reset_outputs();
    res = 1'b1;

    // word write then read, big-endian layout in memory
    send(MEM_ACCESS_W, MEM_LEN_W, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF);
    check("mem_big_endian", 64'({bus_mem[256], bus_mem[257], bus_mem[258], bus_mem[259]}), 64'hDEADBEEF);
    send(MEM_ACCESS_R, MEM_LEN_W, 1'b0, 1'b0, 32'h100, 32'h0);
    // sub-word reads with extension, and a fetch
    send(MEM_ACCESS_R, MEM_LEN_B, 1'b1, 1'b0, 32'h101, 32'h0);
    send(MEM_ACCESS_R, MEM_LEN_B, 1'b0, 1'b0, 32'h101, 32'h0);
    send(MEM_ACCESS_R, MEM_LEN_H, 1'b1, 1'b0, 32'h102, 32'h0);
    send(MEM_ACCESS_X, MEM_LEN_W, 1'b0, 1'b0, 32'h100, 32'h0);
    // misaligned requests never reach the bus
    send(MEM_ACCESS_R, MEM_LEN_H, 1'b0, 1'b0, 32'h103, 32'h0);
    send(MEM_ACCESS_W, MEM_LEN_W, 1'b0, 1'b0, 32'h102, 32'h12345678);
    send(MEM_ACCESS_X, MEM_LEN_H, 1'b0, 1'b0, 32'h104, 32'h0);

    // NONE-type request is ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_type = MEM_ACCESS_NONE;
    repeat (3) begin
      @(negedge clk);
      check("none_ignored", 64'(req_ready), 64'd1);
    end
    req_valid = 1'b0;

    // timeout
    ready_mode = 2;
    send(MEM_ACCESS_R, MEM_LEN_W, 1'b0, 1'b0, 32'h104, 32'h0);
    ready_mode = 0;

    // IO byte write under random stalls
    ready_mode = 1;
    send(MEM_ACCESS_W, MEM_LEN_B, 1'b0, 1'b1, 32'h1, 32'hFFFFFF41);
    check("io_char", 64'(io_char), 64'h41);
    check("io_writes", 64'(io_writes), 64'd1);

    // randomized traffic, alternating stall modes
    for (int r = 0; r < 60; r++) begin
      ready_mode = (r % 3 == 0) ? 0 : 1;
      t = mem_access_e'($urandom_range(1, 3));
      l = mem_len_e'($urandom_range(0, 2));
      if (t == MEM_ACCESS_X && $urandom_range(0, 3) != 0) l = MEM_LEN_W;
      n = nbytes_of(l);
      a = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) a = a - (a % 32'(n));
      send(t, l, 1'($urandom_range(0, 1)), 1'b0, a, $urandom);
    end
    ready_mode = 0;

    // asynchronous reset during a stalled bus access
    ready_mode = 2;
    @(negedge clk);
    req_valid = 1'b1; req_type = MEM_ACCESS_R; req_len = MEM_LEN_W; req_addr = 32'h108;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_in_bus", 64'(db_access_type), 64'(MEM_ACCESS_R));
    #3;
    res = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    res = 1'b1;
    ready_mode = 0;
    repeat (8) @(negedge clk);
    check("post_reset_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
